tmr_err_monitor: RTL and testbench

Collects the mismatch flags produced by the design's majority voters and turns them into sticky per-voter status, a saturating event counter, and a threshold alarm with a one-cycle interrupt pulse. Firmware clears the status through a four-phase req/ack handshake. There is a single instance, placed outside the triplicated logic and excluded from triplication, because it observes that logic. Its inputs are the voters' error outputs, which are synchronous to `clk`.

---
 rtl/tmr_err_monitor.sv | 174 +++++++++++++++++
 tb/tb_tmr_err_monitor.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_err_monitor.sv
// ---------------------------------------------------------------------------
// tmr_err_monitor
//
// Purpose:
//   Watches the mismatch flags of the majority voters and turns them into
//   sticky per-voter status, a saturating event counter, and a threshold
//   alarm with a one-cycle interrupt pulse. Firmware clears the status with
//   a four-phase req/ack handshake. There is one instance of this block. It
//   sits outside the triplicated logic because it observes that logic.
//
// Ports:
//   clk        in   system clock, rising edge
//   rstn       in   asynchronous active-low reset
//   err_i      in   [N_ERR]  voter mismatch flags (level, synchronous to clk)
//   clr_req    in   clear request (four-phase level)
//   clr_ack    out  clear acknowledge
//   err_sticky out  [N_ERR]  per-voter sticky error bits
//   err_cnt    out  [CNT_W]  saturating count of error events
//   any_err    out  registered OR of err_i
//   alarm      out  level, count has reached THRESH (THRESH=0 disables)
//   irq        out  one-cycle pulse, one cycle after alarm rises
// ---------------------------------------------------------------------------
module tmr_err_monitor #(
    parameter int          N_ERR  = 4,
    parameter int          CNT_W  = 16,
    parameter int unsigned THRESH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N_ERR-1:0] err_i,
    input  logic             clr_req,
    output logic             clr_ack,
    output logic [N_ERR-1:0] err_sticky,
    output logic [CNT_W-1:0] err_cnt,
    output logic             any_err,
    output logic             alarm,
    output logic             irq
);

    // The sum is 6 bits wider than the counter, so up to 32 simultaneous
    // events can be added before the clamp without wrapping.
    localparam int                SUM_W    = CNT_W + 6;
    // The threshold compare is done 32 bits wider than the counter. A
    // THRESH above the counter range then never alarms instead of aliasing.
    localparam int                CMP_W    = CNT_W + 32;
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CMP_W-1:0]  THRESH_C = CMP_W'(THRESH);
    localparam bit                ALARM_EN = (THRESH != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ERR   = 2'd1,
        ALARM = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        H_IDLE = 2'd0,
        H_CLR  = 2'd1,
        H_ACK  = 2'd2
    } hs_t;

    state_t             state_reg, state_next;
    hs_t                hs_reg, hs_next;

    logic [N_ERR-1:0]   err_prev_reg;
    logic [N_ERR-1:0]   err_sticky_reg, err_sticky_next;
    logic [CNT_W-1:0]   err_cnt_reg, err_cnt_next;
    logic               any_err_reg;
    logic               alarm_reg;
    logic               alarm_d_reg;
    logic               irq_reg;
    logic               clr_ack_reg;

    logic [N_ERR-1:0]   ev;
    logic [5:0]         ev_pop;
    logic [SUM_W-1:0]   cnt_sum;
    logic [CNT_W-1:0]   cnt_sat;

    // A line creates an event only on its rising edge. A line held high is
    // one event, and it must drop for a cycle before it can fire again.
    for (genvar gi = 0; gi < N_ERR; gi++) begin : g_edge
        assign ev[gi] = err_i[gi] & ~err_prev_reg[gi];
    end

    always_comb begin
        ev_pop = '0;
        for (int i = 0; i < N_ERR; i++) begin
            ev_pop = ev_pop + 6'(ev[i]);
        end
    end

    always_comb begin
        cnt_sum = SUM_W'(err_cnt_reg) + SUM_W'(ev_pop);
        cnt_sat = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
    end

    // Clear handshake
    always_comb begin
        hs_next = hs_reg;
        case (hs_reg)
            H_IDLE:  if (clr_req)  hs_next = H_CLR;
            H_CLR:                 hs_next = H_ACK;
            H_ACK:   if (!clr_req) hs_next = H_IDLE;
            default:               hs_next = H_IDLE;
        endcase
    end

    // Status update and FSM. The FSM state comes from the count being
    // registered this cycle, so a burst can go from IDLE to ALARM in one step.
    always_comb begin
        err_sticky_next = err_sticky_reg;
        err_cnt_next    = err_cnt_reg;
        state_next      = state_reg;

        if (hs_reg == H_CLR) begin
            // Events seen in the clear cycle are dropped on purpose.
            err_sticky_next = '0;
            err_cnt_next    = '0;
            state_next      = IDLE;
        end else begin
            err_sticky_next = err_sticky_reg | ev;
            err_cnt_next    = cnt_sat;

            // The count never decreases outside a clear, so ALARM is
            // held explicitly. Only the clear branch above leaves it.
            if (state_reg == ALARM) begin
                state_next = ALARM;
            end else if (err_cnt_next == '0) begin
                state_next = IDLE;
            end else if (ALARM_EN && (CMP_W'(err_cnt_next) >= THRESH_C)) begin
                state_next = ALARM;
            end else begin
                state_next = ERR;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg      <= IDLE;
            hs_reg         <= H_IDLE;
            err_prev_reg   <= '0;
            err_sticky_reg <= '0;
            err_cnt_reg    <= '0;
            any_err_reg    <= 1'b0;
            alarm_reg      <= 1'b0;
            alarm_d_reg    <= 1'b0;
            irq_reg        <= 1'b0;
            clr_ack_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            hs_reg         <= hs_next;
            // Keeps tracking through a clear. A line held high across the
            // clear therefore does not look like a new rising edge afterwards.
            err_prev_reg   <= err_i;
            err_sticky_reg <= err_sticky_next;
            err_cnt_reg    <= err_cnt_next;
            any_err_reg    <= |err_i;
            alarm_reg      <= (state_next == ALARM);
            alarm_d_reg    <= alarm_reg;
            // Rising edge of alarm, one cycle late.
            irq_reg        <= alarm_reg & ~alarm_d_reg;
            clr_ack_reg    <= (hs_next == H_ACK);
        end
    end

    assign clr_ack    = clr_ack_reg;
    assign err_sticky = err_sticky_reg;
    assign err_cnt    = err_cnt_reg;
    assign any_err    = any_err_reg;
    assign alarm      = alarm_reg;
    assign irq        = irq_reg;

endmodule

// File: tb/tb_tmr_err_monitor.sv
// ---------------------------------------------------------------------------
// tb_tmr_err_monitor
//
// Scoreboard bench for tmr_err_monitor (N_ERR=4, CNT_W=4, THRESH=8).
// A narrow counter lets saturation and the alarm threshold both be reached.
// At each clock edge the driver advances a behavioural model and pushes the
// expected outputs. A monitor pops one entry and compares it on each
// falling edge.
// ---------------------------------------------------------------------------
module tb_tmr_err_monitor;

    localparam int N_ERR  = 4;
    localparam int CNT_W  = 4;
    localparam int THRESH = 8;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rstn;
    logic [N_ERR-1:0] err_i;
    logic             clr_req;
    logic             clr_ack;
    logic [N_ERR-1:0] err_sticky;
    logic [CNT_W-1:0] err_cnt;
    logic             any_err;
    logic             alarm;
    logic             irq;

    always #5 clk = ~clk;

    tmr_err_monitor #(
        .N_ERR  (N_ERR),
        .CNT_W  (CNT_W),
        .THRESH (THRESH)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .err_i      (err_i),
        .clr_req    (clr_req),
        .clr_ack    (clr_ack),
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt),
        .any_err    (any_err),
        .alarm      (alarm),
        .irq        (irq)
    );

    typedef struct {
        int sticky;
        int cnt;
        int any;
        int alm;
        int irq;
        int ack;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Behavioural model state
    int   m_prev, m_sticky, m_cnt, m_any, m_alarm, m_irq, m_ack;
    int   m_entered;   // alarm was raised at the last edge
    int   m_phase;     // 0 idle, 1 clearing, 2 acknowledged

    function automatic void model_reset();
        m_prev = 0; m_sticky = 0; m_cnt = 0; m_any = 0;
        m_alarm = 0; m_irq = 0; m_ack = 0; m_entered = 0; m_phase = 0;
    endfunction

    function automatic int popcnt(input int v);
        int c = 0;
        for (int i = 0; i < N_ERR; i++) c += (v >> i) & 1;
        return c;
    endfunction

    // One rising edge of the model, using the inputs the DUT sampled there.
    function automatic void model_step();
        int e;
        int ev;
        exp_t x;
        e = int'(err_i);
        if (!rstn) begin
            model_reset();
        end else begin
            ev = e & ~m_prev;
            m_irq = m_entered;
            m_entered = 0;
            if (m_phase == 1) begin
                m_sticky = 0;
                m_cnt    = 0;
                m_alarm  = 0;
                m_phase  = 2;
            end else begin
                m_sticky = m_sticky | ev;
                m_cnt    = m_cnt + popcnt(ev);
                if (m_cnt > CMAX) m_cnt = CMAX;
                if (m_alarm == 0 && m_cnt >= THRESH) begin
                    m_alarm   = 1;
                    m_entered = 1;
                end
                if (m_phase == 0 && clr_req) m_phase = 1;
                else if (m_phase == 2 && !clr_req) m_phase = 0;
            end
            m_any  = (e != 0) ? 1 : 0;
            m_prev = e;
            m_ack  = (m_phase == 2) ? 1 : 0;
        end
        x.sticky = m_sticky; x.cnt = m_cnt; x.any = m_any;
        x.alm = m_alarm; x.irq = m_irq; x.ack = m_ack;
        exp_q.push_back(x);
    endfunction

    task automatic cmp1(input string tag, input string fld, input int got, input int want);
        if (got != want) begin
            n_bad++;
            $display("FAIL %s cyc=%0d %s: got %0d want %0d", tag, cyc, fld, got, want);
        end
    endtask

    task automatic check_vec(input exp_t x, input string tag);
        n_vec++;
        cmp1(tag, "err_sticky", int'(err_sticky), x.sticky);
        cmp1(tag, "err_cnt",    int'(err_cnt),    x.cnt);
        cmp1(tag, "any_err",    int'(any_err),    x.any);
        cmp1(tag, "alarm",      int'(alarm),      x.alm);
        cmp1(tag, "irq",        int'(irq),        x.irq);
        cmp1(tag, "clr_ack",    int'(clr_ack),    x.ack);
        $display("vec %0d cyc=%0d %s err_i=%h req=%0d sticky=%h cnt=%0d any=%0d alarm=%0d irq=%0d ack=%0d",
                 n_vec, cyc, tag, err_i, clr_req, err_sticky, err_cnt, any_err, alarm, irq, clr_ack);
    endtask

    // Monitor: one comparison per cycle when an expectation is waiting.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) check_vec(exp_q.pop_front(), "scb");
        end
    end

    // Apply inputs for one cycle. This is entered just after a rising edge
    // and returns just after the next one.
    task automatic cycle(input logic [N_ERR-1:0] e, input logic r);
        err_i   = e;
        clr_req = r;
        @(posedge clk);
        cyc++;
        model_step();
        #1;
    endtask

    task automatic do_clear(input logic [N_ERR-1:0] e);
        cycle(e, 1'b1);
        cycle(e, 1'b1);
        cycle(e, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t z;
        logic [N_ERR-1:0] e;
        logic r;
        z.sticky = 0; z.cnt = 0; z.any = 0; z.alm = 0; z.irq = 0; z.ack = 0;
        model_reset();
        rstn = 1'b0; err_i = '0; clr_req = 1'b0;

        // Reset state
        repeat (3) cycle('0, 1'b0);
        rstn = 1'b1;
        cycle('0, 1'b0);

        // Single event held for 3 cycles
        repeat (3) cycle(4'b0100, 1'b0);
        repeat (2) cycle('0, 1'b0);
        do_clear('0);

        // Eight separate pulses reach the threshold, then idle with alarm held
        for (int i = 0; i < 8; i++) begin
            cycle(4'b0001, 1'b0);
            cycle('0, 1'b0);
            cycle('0, 1'b0);
        end
        repeat (20) cycle('0, 1'b0);
        cycle(4'b0001, 1'b0);          // count 9
        cycle('0, 1'b0);

        // Clear from ALARM. One event lands in the clear cycle, one in ack.
        cycle('0, 1'b1);
        cycle(4'b0100, 1'b1);
        cycle('0, 1'b1);
        cycle(4'b1000, 1'b1);
        cycle('0, 1'b0);
        cycle('0, 1'b0);
        do_clear('0);

        // Simultaneous events saturate the counter
        for (int i = 0; i < 10; i++) cycle((i % 2 == 0) ? 4'hF : 4'h0, 1'b0);
        do_clear('0);

        // Line held high across a clear is not counted again
        repeat (2) cycle(4'b0010, 1'b0);
        do_clear(4'b0010);
        repeat (3) cycle(4'b0010, 1'b0);
        cycle('0, 1'b0);
        cycle(4'b0010, 1'b0);
        cycle('0, 1'b0);

        // Asynchronous reset while acknowledged
        cycle(4'b0001, 1'b0);
        cycle('0, 1'b1);
        cycle('0, 1'b1);
        @(negedge clk);
        #1;
        rstn = 1'b0;
        model_reset();
        #1;
        check_vec(z, "async_rst");
        cycle('0, 1'b1);
        cycle('0, 1'b1);
        rstn = 1'b1;
        cycle('0, 1'b1);
        cycle('0, 1'b1);
        cycle('0, 1'b0);
        cycle('0, 1'b0);

        // Randomized traffic with occasional clears
        e = '0;
        r = 1'b0;
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < N_ERR; b++)
                if ($urandom_range(0, 3) == 0) e[b] = ~e[b];
            if (!r && $urandom_range(0, 19) == 0) r = 1'b1;
            else if (r && $urandom_range(0, 2) == 0) r = 1'b0;
            cycle(e, r);
        end
        cycle('0, 1'b0);

        @(negedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
